dac_serial_tx: RTL

Serial transmitter for the board's 16-bit SPI-style DAC. Accepts one sample word plus a 4-bit command over a valid/ready handshake, then shifts a 24-bit frame out on DAC_SYNC / DAC_SCLK / DAC_DIN, MSB first. It sits directly upstream of the top-level DAC pins, between any sample source (NCO, register file, test pattern) and the DAC.

---
 rtl/dac_serial_tx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dac_serial_tx.sv
// Serial transmitter for a 16-bit SPI-style DAC: captures {cmd, data, 4'b0} on handshake
// and shifts it MSB first on DAC_SYNC/DAC_SCLK/DAC_DIN, with every output driven from a flop.
module dac_serial_tx #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        CLK_50_MAX10,
  input  logic        CPU_RESET,
  input  logic [15:0] SAMPLE_DATA,
  input  logic [3:0]  SAMPLE_CMD,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  output logic        BUSY,
  output logic        DAC_SYNC,
  output logic        DAC_SCLK,
  output logic        DAC_DIN
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    BIT_LAST  = 5'd23;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   half_q, half_d;
  logic [4:0]      bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [23:0]     shreg_q, shreg_d;
  logic            sync_q, sync_d;
  logic            sclk_q, sclk_d;
  logic            din_q, din_d;
  logic            rdy_q, rdy_d;
  logic            handshake;

  assign handshake = SAMPLE_VALID && rdy_q;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = SHIFT;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          // Bit 23 goes straight to DIN; the register holds the remaining 23 bits.
          din_d   = SAMPLE_CMD[3];
          shreg_d = {SAMPLE_CMD[2:0], SAMPLE_DATA, 4'b0000, 1'b0};
          half_d  = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            // Rising edge after the 24th fall closes the frame.
            state_d = GAP;
            sync_d  = 1'b1;
            sclk_d  = 1'b1;
            din_d   = 1'b0;
            gap_d   = '0;
            bit_d   = '0;
          end else begin
            sclk_d  = 1'b1;
            din_d   = shreg_q[23];
            shreg_d = {shreg_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK_50_MAX10) begin
    if (CPU_RESET) begin
      state_q <= IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      rdy_q   <= rdy_d;
    end
  end

  assign SAMPLE_READY = rdy_q;
  assign BUSY         = (state_q != IDLE);
  assign DAC_SYNC     = sync_q;
  assign DAC_SCLK     = sclk_q;
  assign DAC_DIN      = din_q;

endmodule
